// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and geometry helpers for the set-associative read cache
package cache_pkg;
  typedef enum logic {IDLE, REFILL} state_t;
  function automatic int calc_tag_w(input int addr_w, input int offset_w, input int set_w);
    return addr_w - offset_w - set_w;
  endfunction
  function automatic int calc_line_w(input int word_w, input int offset_w);
    return word_w << offset_w;
  endfunction
  function automatic int calc_sets(input int set_w);
    return 1 << set_w;
  endfunction
  localparam int TAG_W  = calc_tag_w(30, 2, 2);
  localparam int LINE_W = calc_line_w(32, 2);
  localparam int SETS   = calc_sets(2);
endpackage

// File: rtl/cache_rd_sa_if.sv
// cache_rd_sa_if: processor read port and line-memory port of the read cache
interface cache_rd_sa_if #(
  parameter int ADDR_W   = 30,
  parameter int WORD_W   = 32,
  parameter int OFFSET_W = 2
);
  logic                           proc_read;
  logic                           proc_flush;
  logic [ADDR_W-1:0]              proc_addr;
  logic [WORD_W-1:0]              proc_rdata;
  logic                           proc_stall;
  logic                           mem_read;
  logic [ADDR_W-OFFSET_W-1:0]     mem_addr;
  logic [(WORD_W<<OFFSET_W)-1:0]  mem_rdata;
  logic                           mem_ready;
  modport slave (
    input  proc_read, proc_flush, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );
  modport master (
    output proc_read, proc_flush, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );
endinterface

// File: rtl/cache_rd_way.sv
// cache_rd_way: one way's valid/tag/data storage with combinational lookup
module cache_rd_way #(
  parameter int TAG_W  = 26,
  parameter int LINE_W = 128,
  parameter int SET_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [SET_W-1:0]  rd_set,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              vld,
  output logic              hit,
  output logic [LINE_W-1:0] line,
  input  logic              fill_en,
  input  logic [SET_W-1:0]  fill_set,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line
);
  localparam int NS = 1 << SET_W;
  logic [NS-1:0]     valid;
  logic [TAG_W-1:0]  tags [NS];
  logic [LINE_W-1:0] data [NS];
  // storage: clear everything on reset, drop valid bits on flush, write tag/data with valid on fill
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < NS; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      if (clr) valid <= '0;
      else if (fill_en) valid[fill_set] <= 1'b1;
      if (fill_en) begin
        tags[fill_set] <= fill_tag;
        data[fill_set] <= fill_line;
      end
    end
  end
  assign vld  = valid[rd_set];
  assign hit  = vld && tags[rd_set] == rd_tag;
  assign line = data[rd_set];
endmodule

// File: rtl/cache_rd_sa.sv
// cache_rd_sa: read-only 1/2-way set-associative cache with LRU, flush and saturating hit/miss counters
module cache_rd_sa
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 30,
  parameter int WORD_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int SET_W    = 2,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             proc_reset,
  cache_rd_sa_if.slave     bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int TW = calc_tag_w(ADDR_W, OFFSET_W, SET_W);
  localparam int LW = calc_line_w(WORD_W, OFFSET_W);
  localparam int NS = calc_sets(SET_W);
  state_t                state;
  logic [NS-1:0]         lru;
  logic                  vic, nv, hw;
  logic [WAYS-1:0]       hit_w, vld_w;
  logic [LW-1:0]         way_line [WAYS];
  logic [LW-1:0]         hit_line;
  logic                  idle, flush_go, rd_hit, rd_miss, fill_en;
  logic [OFFSET_W-1:0]   off;
  logic [SET_W-1:0]      set;
  logic [TW-1:0]         tag;
  function automatic logic [WORD_W-1:0] pick(input logic [LW-1:0] l, input logic [OFFSET_W-1:0] o);
    return l[o*WORD_W +: WORD_W];
  endfunction
  assign off = bus.proc_addr[OFFSET_W-1:0];
  assign set = bus.proc_addr[OFFSET_W +: SET_W];
  assign tag = bus.proc_addr[ADDR_W-1 -: TW];
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_rd_way #(.TAG_W(TW), .LINE_W(LW), .SET_W(SET_W)) u_way (
      .clk(clk), .rst(proc_reset), .clr(flush_go),
      .rd_set(set), .rd_tag(tag),
      .vld(vld_w[g]), .hit(hit_w[g]), .line(way_line[g]),
      .fill_en(fill_en && int'(vic) == g), .fill_set(set), .fill_tag(tag), .fill_line(bus.mem_rdata)
    );
  end
  // hit-way mux and victim choice: first invalid way, otherwise the set's LRU way
  always_comb begin
    hit_line = '0;
    hw = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (hit_w[i]) begin
        hit_line = way_line[i];
        hw = 1'(i);
      end
    end
    nv = (WAYS == 2) && vld_w[0] && (!vld_w[WAYS-1] || lru[set]);
  end
  assign idle           = state == IDLE;
  assign flush_go       = idle && bus.proc_flush;
  assign rd_hit         = idle && !bus.proc_flush && bus.proc_read && |hit_w;
  assign rd_miss        = idle && !bus.proc_flush && bus.proc_read && !(|hit_w);
  assign fill_en        = !idle && bus.mem_ready;
  assign bus.proc_stall = flush_go || rd_miss || (!idle && !bus.mem_ready);
  assign bus.proc_rdata = rd_hit ? pick(hit_line, off) : fill_en ? pick(bus.mem_rdata, off) : '0;
  // control FSM: launch refill on miss, finish on mem_ready, maintain LRU and counters
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state        <= IDLE;
      bus.mem_read <= 1'b0;
      bus.mem_addr <= '0;
      lru          <= '0;
      vic          <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      if (flush_go) lru <= '0;
      else if (rd_hit) lru[set] <= ~hw;
      else if (fill_en) lru[set] <= ~vic;
      if (rd_hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
      if (rd_miss && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
      if (rd_miss) begin
        state        <= REFILL;
        bus.mem_read <= 1'b1;
        bus.mem_addr <= bus.proc_addr[ADDR_W-1:OFFSET_W];
        vic          <= nv;
      end else if (fill_en) begin
        state        <= IDLE;
        bus.mem_read <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cache_rd_sa.sv
// tb_cache_rd_sa: scoreboard bench for a 2-way (2-bit counters) and a direct-mapped cache instance
module tb_cache_rd_sa;
  logic         clk = 1'b0;
  logic         proc_reset = 1'b1;
  logic         sel = 1'b0;
  logic         rd = 1'b0, fl = 1'b0, rdy = 1'b0;
  logic [29:0]  ad = '0;
  logic [127:0] mdata = '0;
  logic         stall, mread;
  logic [31:0]  rdata;
  logic [27:0]  maddr;
  logic [15:0]  hc, mc;
  logic [1:0]   hc0, mc0;
  logic [15:0]  hc1, mc1;
  int           total = 0, bad = 0;
  logic [31:0]  q[$];

  always #5 clk = ~clk;

  cache_rd_sa_if #(.ADDR_W(30), .WORD_W(32), .OFFSET_W(2)) b0 ();
  cache_rd_sa_if #(.ADDR_W(30), .WORD_W(32), .OFFSET_W(2)) b1 ();

  cache_rd_sa #(.WAYS(2), .CNT_W(2)) u0 (.clk(clk), .proc_reset(proc_reset), .bus(b0), .hit_cnt(hc0), .miss_cnt(mc0));
  cache_rd_sa #(.WAYS(1), .CNT_W(16)) u1 (.clk(clk), .proc_reset(proc_reset), .bus(b1), .hit_cnt(hc1), .miss_cnt(mc1));

  assign b0.proc_read  = rd && !sel;
  assign b0.proc_flush = fl && !sel;
  assign b0.proc_addr  = ad;
  assign b0.mem_rdata  = mdata;
  assign b0.mem_ready  = rdy && !sel;
  assign b1.proc_read  = rd && sel;
  assign b1.proc_flush = fl && sel;
  assign b1.proc_addr  = ad;
  assign b1.mem_rdata  = mdata;
  assign b1.mem_ready  = rdy && sel;
  assign stall = sel ? b1.proc_stall : b0.proc_stall;
  assign mread = sel ? b1.mem_read   : b0.mem_read;
  assign rdata = sel ? b1.proc_rdata : b0.proc_rdata;
  assign maddr = sel ? b1.mem_addr   : b0.mem_addr;
  assign hc    = sel ? hc1 : 16'(hc0);
  assign mc    = sel ? mc1 : 16'(mc0);

  function automatic logic [31:0] word_of(input logic [29:0] a);
    return 32'hD000_0000 | (32'(a[29:2]) << 4) | 32'(a[1:0]);
  endfunction

  function automatic logic [127:0] line_of(input logic [27:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = word_of({la, 2'(k)});
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd && !stall && !proc_reset) begin
      if (q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("rdata", rdata, q.pop_front());
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    proc_reset = 1'b1; rd = 1'b0; fl = 1'b0; rdy = 1'b0;
    @(posedge clk); #1;
    proc_reset = 1'b0;
  endtask

  task automatic req(input logic [29:0] a, input bit exp_hit, input int lat = 2);
    ad = a; rd = 1'b1; q.push_back(word_of(a));
    @(negedge clk);
    chk("stall0", 32'(stall), 32'(!exp_hit));
    if (!exp_hit) begin
      @(posedge clk); #1;
      chk("mem_read", 32'(mread), 32'd1);
      chk("mem_addr", 32'(maddr), 32'(a >> 2));
      repeat (lat - 1) begin
        @(negedge clk);
        chk("hold", 32'(stall), 32'd1);
        @(posedge clk); #1;
      end
      rdy = 1'b1; mdata = line_of(a[29:2]);
      @(negedge clk);
      chk("fill_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      rdy = 1'b0;
      chk("mem_rd_off", 32'(mread), 32'd0);
    end else begin
      @(posedge clk); #1;
    end
    rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mread", 32'(mread), 32'd0);
    chk("rst_maddr", 32'(maddr), 32'd0);
    chk("rst_hc", 32'(hc), 32'd0);
    chk("rst_mc", 32'(mc), 32'd0);
    req(30'h10, 0, 3);
    req(30'h13, 1);
    chk("cold_hc", 32'(hc), 32'd1);
    chk("cold_mc", 32'(mc), 32'd1);

    do_reset();
    req(30'h10, 0);
    req(30'h20, 0, 1);
    req(30'h11, 1);
    req(30'h30, 0, 4);
    req(30'h12, 1);
    req(30'h20, 0);
    chk("lru_hc", 32'(hc), 32'd2);
    chk("lru_mc_sat", 32'(mc), 32'd3);

    do_reset();
    req(30'h10, 0);
    fl = 1'b1; rd = 1'b1; ad = 30'h10;
    @(negedge clk);
    chk("flush_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    fl = 1'b0; rd = 1'b0;
    chk("flush_nomem", 32'(mread), 32'd0);
    chk("flush_hc", 32'(hc), 32'd0);
    chk("flush_mc", 32'(mc), 32'd1);
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    req(30'h10, 0);
    chk("flush_mc2", 32'(mc), 32'd2);

    do_reset();
    ad = 30'h10; rd = 1'b1; q.push_back(word_of(30'h10));
    @(posedge clk); #1;
    chk("mr_mread", 32'(mread), 32'd1);
    @(posedge clk); #1;
    proc_reset = 1'b1; rd = 1'b0; void'(q.pop_back());
    @(posedge clk); #1;
    chk("mr_mread0", 32'(mread), 32'd0);
    chk("mr_stall", 32'(stall), 32'd0);
    chk("mr_hc", 32'(hc), 32'd0);
    chk("mr_mc", 32'(mc), 32'd0);
    proc_reset = 1'b0; rdy = 1'b1; mdata = line_of(28'h4);
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("late_rdy", 32'(mread), 32'd0);
    req(30'h10, 0, 3);
    chk("mr_mc1", 32'(mc), 32'd1);

    do_reset();
    req(30'h10, 0);
    for (int i = 0; i < 5; i++) req(30'h10 | 30'(i % 4), 1);
    chk("sat_hc", 32'(hc), 32'd3);
    chk("sat_mc", 32'(mc), 32'd1);

    sel = 1'b1;
    do_reset();
    req(30'h10, 0);
    req(30'h20, 0);
    req(30'h10, 0);
    chk("dm_hc", 32'(hc), 32'd0);
    chk("dm_mc", 32'(mc), 32'd3);

    chk("sb_left", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
